// File: rtl/regfile_sb.sv
// Parametrised register file with byte-enable writes, optional zero register and
// a per-register busy scoreboard. Define REGFILE_SB_BYPASS_EN for write-through bypass.
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic               Clk,
    input  logic               Clrn,
    input  logic [AW-1:0]      Ra,
    input  logic [AW-1:0]      Rb,
    output logic [WIDTH-1:0]   Qa,
    output logic [WIDTH-1:0]   Qb,
    input  logic [AW-1:0]      Wr,
    input  logic [WIDTH-1:0]   D,
    input  logic               We,
    input  logic [WIDTH/8-1:0] Be,
    input  logic [AW-1:0]      Sr,
    input  logic               Se,
    output logic               Busy_a,
    output logic               Busy_b
);

    localparam int DEPTH    = 2 ** AW;
    localparam int NB       = WIDTH / 8;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [WIDTH-1:0] wrData_d;
    logic             wrEn;

    assign wrEn = We && !(HAS_ZERO && (Wr == '0));

    // Merged write word: the old contents of reg[Wr] with enabled bytes replaced.
    always_comb begin
        wrData_d = regs_q[Wr];
        for (int i = 0; i < NB; i++) begin
            if (Be[i]) begin
                wrData_d[8*i +: 8] = D[8*i +: 8];
            end
        end
    end

    // Set is applied after clear so a same-register issue/retire ends busy.
    always_comb begin
        busy_d = busy_q;
        if (We) begin
            busy_d[Wr] = 1'b0;
        end
        if (Se) begin
            busy_d[Sr] = 1'b1;
        end
        if (HAS_ZERO) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            busy_q <= '0;
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            if (wrEn) begin
                regs_q[Wr] <= wrData_d;
            end
        end
    end

    always_comb begin
        Qa     = regs_q[Ra];
        Qb     = regs_q[Rb];
        Busy_a = busy_q[Ra];
        Busy_b = busy_q[Rb];
`ifdef REGFILE_SB_BYPASS_EN
        if (wrEn && (Ra == Wr)) begin
            Qa = wrData_d;
        end
        if (wrEn && (Rb == Wr)) begin
            Qb = wrData_d;
        end
        if (We && (Ra == Wr)) begin
            Busy_a = 1'b0;
        end
        if (We && (Rb == Wr)) begin
            Busy_b = 1'b0;
        end
`endif
        // Register 0 reads as zero and is never busy.
        if (HAS_ZERO && (Ra == '0)) begin
            Qa     = '0;
            Busy_a = 1'b0;
        end
        if (HAS_ZERO && (Rb == '0)) begin
            Qb     = '0;
            Busy_b = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard testbench for regfile_sb: directed vectors push expectations,
// a negedge monitor pops and compares read data and busy flags.
module tb_regfile_sb;

    logic        Clk;
    logic        Clrn;
    logic [4:0]  Ra, Rb, Wr, Sr;
    logic [31:0] Qa, Qb, D;
    logic        We, Se;
    logic [3:0]  Be;
    logic        Busy_a, Busy_b;

    typedef struct {
        string       name;
        logic [31:0] qa;
        logic [31:0] qb;
        logic        ba;
        logic        bb;
    } expT;

    expT expQ[$];
    logic probe;
    int   checks;
    int   errors;
    bit   bypassOn;

    regfile_sb #(.WIDTH(32), .AW(5), .ZERO_REG(1)) dut (
        .Clk(Clk), .Clrn(Clrn), .Ra(Ra), .Rb(Rb), .Qa(Qa), .Qb(Qb),
        .Wr(Wr), .D(D), .We(We), .Be(Be), .Sr(Sr), .Se(Se),
        .Busy_a(Busy_a), .Busy_b(Busy_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one cycle's write/issue inputs just after the rising edge.
    task automatic applyStimulus(input logic we, input logic [4:0] wr, input logic [31:0] d,
                                 input logic [3:0] be, input logic se, input logic [4:0] sr);
        @(posedge Clk);
        #1;
        We = we;
        Wr = wr;
        D  = d;
        Be = be;
        Se = se;
        Sr = sr;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    endtask

    // Set read addresses and queue the expected response for this cycle.
    task automatic checkOutput(input string name, input logic [4:0] ra, input logic [4:0] rb,
                               input logic [31:0] qa, input logic [31:0] qb,
                               input logic ba, input logic bb);
        expT e;
        Ra = ra;
        Rb = rb;
        e.name = name;
        e.qa = qa;
        e.qb = qb;
        e.ba = ba;
        e.bb = bb;
        expQ.push_back(e);
        probe = 1'b1;
        @(negedge Clk);
        #1;
        probe = 1'b0;
    endtask

    always @(negedge Clk) begin
        if (probe) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboard underflow: got probe, required queued expectation");
            end else begin
                expT e;
                e = expQ.pop_front();
                if (Qa !== e.qa) begin
                    errors++;
                    $display("[TB] FAIL %s Qa: got %h, required %h", e.name, Qa, e.qa);
                end
                checks++;
                if (Qb !== e.qb) begin
                    errors++;
                    $display("[TB] FAIL %s Qb: got %h, required %h", e.name, Qb, e.qb);
                end
                checks++;
                if (Busy_a !== e.ba) begin
                    errors++;
                    $display("[TB] FAIL %s Busy_a: got %b, required %b", e.name, Busy_a, e.ba);
                end
                checks++;
                if (Busy_b !== e.bb) begin
                    errors++;
                    $display("[TB] FAIL %s Busy_b: got %b, required %b", e.name, Busy_b, e.bb);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, required finish before 100000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
`ifdef REGFILE_SB_BYPASS_EN
        bypassOn = 1'b1;
`else
        bypassOn = 1'b0;
`endif
        checks = 0;
        errors = 0;
        probe  = 1'b0;
        Clrn = 1'b1;
        Ra = 5'd0; Rb = 5'd0; Wr = 5'd0; Sr = 5'd0;
        D = 32'h0; Be = 4'h0; We = 1'b0; Se = 1'b0;
        #2;
        Clrn = 1'b0;
        checkOutput("rstLow", 5'd5, 5'd31, 32'h0, 32'h0, 1'b0, 1'b0);

        idle();
        Clrn = 1'b1;
        checkOutput("rstRead", 5'd5, 5'd31, 32'h0, 32'h0, 1'b0, 1'b0);

        applyStimulus(1'b1, 5'd3, 32'h11223344, 4'b1111, 1'b0, 5'd0);
        checkOutput("wr3Same", 5'd3, 5'd3,
                    bypassOn ? 32'h11223344 : 32'h0, bypassOn ? 32'h11223344 : 32'h0, 1'b0, 1'b0);

        applyStimulus(1'b1, 5'd3, 32'hAABBCCDD, 4'b0101, 1'b0, 5'd0);
        checkOutput("byteSame", 5'd3, 5'd0,
                    bypassOn ? 32'h11BB33DD : 32'h11223344, 32'h0, 1'b0, 1'b0);

        idle();
        checkOutput("byteWr", 5'd3, 5'd3, 32'h11BB33DD, 32'h11BB33DD, 1'b0, 1'b0);

        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 4'b1111, 1'b1, 5'd0);
        checkOutput("zeroSame", 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);

        idle();
        checkOutput("zeroReg", 5'd0, 5'd3, 32'h0, 32'h11BB33DD, 1'b0, 1'b0);

        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd7);
        checkOutput("sbIssue", 5'd7, 5'd7, 32'h0, 32'h0, 1'b0, 1'b0);

        idle();
        checkOutput("sbSet", 5'd7, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);

        applyStimulus(1'b1, 5'd7, 32'hCAFE0007, 4'b1111, 1'b0, 5'd0);
        checkOutput("sbRetire", 5'd7, 5'd0,
                    bypassOn ? 32'hCAFE0007 : 32'h0, 32'h0, bypassOn ? 1'b0 : 1'b1, 1'b0);

        idle();
        checkOutput("sbClear", 5'd7, 5'd7, 32'hCAFE0007, 32'hCAFE0007, 1'b0, 1'b0);

        applyStimulus(1'b1, 5'd7, 32'h0000BEEF, 4'b0011, 1'b1, 5'd7);
        checkOutput("sbBothSame", 5'd7, 5'd0,
                    bypassOn ? 32'hCAFEBEEF : 32'hCAFE0007, 32'h0, 1'b0, 1'b0);

        idle();
        checkOutput("sbSetWins", 5'd7, 5'd3, 32'hCAFEBEEF, 32'h11BB33DD, 1'b1, 1'b0);

        applyStimulus(1'b1, 5'd7, 32'hFFFFFFFF, 4'b0000, 1'b1, 5'd8);
        checkOutput("beZeroSame", 5'd7, 5'd8, 32'hCAFEBEEF, 32'h0, bypassOn ? 1'b0 : 1'b1, 1'b0);

        idle();
        checkOutput("sbIndep", 5'd7, 5'd8, 32'hCAFEBEEF, 32'h0, 1'b0, 1'b1);

        applyStimulus(1'b1, 5'd9, 32'h12345678, 4'b1111, 1'b0, 5'd0);
        checkOutput("byp9", 5'd9, 5'd9,
                    bypassOn ? 32'h12345678 : 32'h0, bypassOn ? 32'h12345678 : 32'h0, 1'b0, 1'b0);

        idle();
        checkOutput("byp9Next", 5'd9, 5'd9, 32'h12345678, 32'h12345678, 1'b0, 1'b0);

        applyStimulus(1'b1, 5'd4, 32'h00000055, 4'b1111, 1'b0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd4);
        idle();
        checkOutput("pre4", 5'd4, 5'd8, 32'h00000055, 32'h0, 1'b1, 1'b1);

        applyStimulus(1'b1, 5'd4, 32'h000000AA, 4'b1111, 1'b0, 5'd0);
        #1;
        Clrn = 1'b0;
        checkOutput("rstMid", 5'd4, 5'd8, 32'h0, 32'h0, 1'b0, 1'b0);

        idle();
        Clrn = 1'b1;
        checkOutput("rstDiscard", 5'd4, 5'd9, 32'h0, 32'h0, 1'b0, 1'b0);

        idle();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL queueDrain: got %0d pending, required 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
